poly_horner: RTL and testbench



---
 rtl/poly_horner_pkg.sv | 21 ++
 rtl/poly_horner_if.sv | 23 ++
 rtl/poly_horner_soma_multiplica_p.sv | 37 +++
 rtl/poly_horner.sv | 107 ++++++++++
 tb/tb_poly_horner.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/poly_horner_pkg.sv
// Shared types and defaults for the Horner polynomial evaluator.
package poly_horner_pkg;

   localparam int unsigned DEFAULT_WIDTH  = 16;
   localparam int unsigned DEFAULT_DEGREE = 2;

   // Controller state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } stateT;

   // Shared ALU operation select
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_MUL = 1'b1
   } aluOpT;

endpackage

// File: rtl/poly_horner_if.sv
// Request/result bundle between the operand source, the evaluator and the consumer.
interface poly_horner_if #(
   parameter int unsigned WIDTH  = poly_horner_pkg::DEFAULT_WIDTH,
   parameter int unsigned DEGREE = poly_horner_pkg::DEFAULT_DEGREE
);
   logic                          start;
   logic [WIDTH-1:0]              x;
   logic [(DEGREE+1)*WIDTH-1:0]   coef;
   logic                          busy;
   logic                          done;
   logic [WIDTH-1:0]              y;
   logic                          ovf;

   modport master (
      output start, x, coef,
      input  busy, done, y, ovf
   );

   modport slave (
      input  start, x, coef,
      output busy, done, y, ovf
   );
endinterface

// File: rtl/poly_horner_soma_multiplica_p.sv
// soma_multiplica_p: combinational add/multiply unit shared by every Horner step.
// Optional feature macro: POLY_HORNER_SATURATE_EN clamps overflowing results to all-ones;
// otherwise results wrap modulo 2^WIDTH. Overflow is flagged in both builds.
module soma_multiplica_p
   import poly_horner_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  aluOpT            op,
   output logic [WIDTH-1:0] result_c,
   output logic             overflow_c
);

   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   wrapped;

   // Full-width product/sum, then truncate (or clamp) and flag overflow
   always_comb begin
      product    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      sum        = (WIDTH+1)'(a) + (WIDTH+1)'(b);
      wrapped    = sum[WIDTH-1:0];
      overflow_c = sum[WIDTH];
      if (op == OP_MUL) begin
         wrapped    = product[WIDTH-1:0];
         overflow_c = |product[2*WIDTH-1:WIDTH];
      end
`ifdef POLY_HORNER_SATURATE_EN
      result_c = overflow_c ? {WIDTH{1'b1}} : wrapped;
`else
      result_c = wrapped;
`endif
   end

endmodule

// File: rtl/poly_horner.sv
// poly_horner: evaluates c_N*x^N + ... + c_0 by Horner's method, one MUL/ADD per cycle
// on a single shared unit. Feature macro POLY_HORNER_SATURATE_EN (in soma_multiplica_p)
// selects saturating instead of wrapping arithmetic.
module poly_horner
   import poly_horner_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned DEGREE = DEFAULT_DEGREE
) (
   input  logic          clk,
   input  logic          rst,
   poly_horner_if.slave  bus
);

   localparam int unsigned IDXW = $clog2(DEGREE + 1);

   stateT                        state;
   logic [DEGREE:0][WIDTH-1:0]   coefReg;
   logic [WIDTH-1:0]             xReg;
   logic [WIDTH-1:0]             acc;
   logic [IDXW-1:0]              idx;
   logic                         ovfInt;
   logic [WIDTH-1:0]             yReg;
   logic                         ovfReg;
   logic                         busyReg;
   logic                         doneReg;

   aluOpT                        aluOp;
   logic [WIDTH-1:0]             aluB;
   logic [WIDTH-1:0]             aluResult;
   logic                         aluOvf;

   // Operand steering: multiply by captured x, or add the current coefficient
   assign aluOp = (state == MUL) ? OP_MUL : OP_ADD;
   assign aluB  = (state == MUL) ? xReg : coefReg[idx];

   soma_multiplica_p #(.WIDTH(WIDTH)) uAlu (
      .a          (acc),
      .b          (aluB),
      .op         (aluOp),
      .result_c   (aluResult),
      .overflow_c (aluOvf)
   );

   // Controller and datapath registers; busy/done follow the registered state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         coefReg <= '0;
         xReg    <= '0;
         acc     <= '0;
         idx     <= '0;
         ovfInt  <= 1'b0;
         yReg    <= '0;
         ovfReg  <= 1'b0;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  coefReg <= bus.coef;
                  xReg    <= bus.x;
                  acc     <= bus.coef[DEGREE*WIDTH +: WIDTH];
                  idx     <= IDXW'(DEGREE - 1);
                  ovfInt  <= 1'b0;
                  busyReg <= 1'b1;
                  state   <= MUL;
               end else begin
                  busyReg <= 1'b0;
                  state   <= IDLE;
               end
            end
            MUL: begin
               acc    <= aluResult;
               ovfInt <= ovfInt | aluOvf;
               state  <= ADD;
            end
            ADD: begin
               acc    <= aluResult;
               ovfInt <= ovfInt | aluOvf;
               if (idx == '0) begin
                  yReg    <= aluResult;
                  ovfReg  <= ovfInt | aluOvf;
                  busyReg <= 1'b0;
                  doneReg <= 1'b1;
                  state   <= DONE;
               end else begin
                  idx   <= idx - IDXW'(1);
                  state <= MUL;
               end
            end
            default: begin
               busyReg <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busyReg;
   assign bus.done = doneReg;
   assign bus.y    = yReg;
   assign bus.ovf  = ovfReg;

endmodule

// File: tb/tb_poly_horner.sv
// Directed bench for poly_horner (WIDTH=16, DEGREE=2), expected values computed by hand.
module tb_poly_horner;

   localparam int unsigned W = 16;
   localparam int unsigned D = 2;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   poly_horner_if #(.WIDTH(W), .DEGREE(D)) bus ();

   poly_horner #(.WIDTH(W), .DEGREE(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One evaluation: accept at E0, done exactly 4 edges later, busy for 4 cycles
   task automatic runEval(input string tag, input logic [W-1:0] xv, input logic [W-1:0] c2,
                          input logic [W-1:0] c1, input logic [W-1:0] c0,
                          input logic [W-1:0] expY, input logic expOvf);
      bus.x     = xv;
      bus.coef  = {c2, c1, c0};
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.x     = 16'hDEAD;
      chk({tag, ".busyE0"}, 32'(bus.busy), 32'd1);
      chk({tag, ".doneE0"}, 32'(bus.done), 32'd0);
      for (int k = 1; k < 4; k++) begin
         @(posedge clk); #1;
         chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
         chk({tag, ".doneEarly"}, 32'(bus.done), 32'd0);
      end
      @(posedge clk); #1;
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".busyDone"}, 32'(bus.busy), 32'd0);
      chk({tag, ".y"}, 32'(bus.y), 32'(expY));
      chk({tag, ".ovf"}, 32'(bus.ovf), 32'(expOvf));
      @(posedge clk); #1;
      chk({tag, ".donePulse"}, 32'(bus.done), 32'd0);
      chk({tag, ".yHeld"}, 32'(bus.y), 32'(expY));
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.x     = '0;
      bus.coef  = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.done", 32'(bus.done), 32'd0);
      chk("rst.y", 32'(bus.y), 32'd0);
      chk("rst.ovf", 32'(bus.ovf), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic evaluations: 3x^2+5x+7
      runEval("x4", 16'd4, 16'd3, 16'd5, 16'd7, 16'd75, 1'b0);
      runEval("x0", 16'd0, 16'd3, 16'd5, 16'd7, 16'd7, 1'b0);
      runEval("x1", 16'd1, 16'd3, 16'd5, 16'd7, 16'd15, 1'b0);

      // Product overflow: x^2 at x=256, and sum carry-out: 0xFFFF + 1
`ifdef POLY_HORNER_SATURATE_EN
      runEval("mulOvf", 16'd256, 16'd1, 16'd0, 16'd0, 16'hFFFF, 1'b1);
      runEval("addOvf", 16'd1, 16'd0, 16'hFFFF, 16'd1, 16'hFFFF, 1'b1);
`else
      runEval("mulOvf", 16'd256, 16'd1, 16'd0, 16'd0, 16'h0000, 1'b1);
      runEval("addOvf", 16'd1, 16'd0, 16'hFFFF, 16'd1, 16'h0000, 1'b1);
`endif
      // Overflow flag clears on a clean evaluation
      runEval("ovfClear", 16'd4, 16'd3, 16'd5, 16'd7, 16'd75, 1'b0);

      // start re-pulsed and x changed while busy: ignored
      bus.x     = 16'd4;
      bus.coef  = {16'd3, 16'd5, 16'd7};
      bus.start = 1'b1;
      @(posedge clk); #1;             // E0
      bus.start = 1'b0;
      @(posedge clk); #1;             // E1
      bus.start = 1'b1;
      bus.x     = 16'd9;
      @(posedge clk); #1;             // E2
      chk("ign.busyE2", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;             // E3
      bus.start = 1'b0;
      @(posedge clk); #1;             // E4
      chk("ign.done", 32'(bus.done), 32'd1);
      chk("ign.y", 32'(bus.y), 32'd75);
      @(posedge clk); #1;
      chk("ign.noReaccept", 32'(bus.busy), 32'd0);
      chk("ign.doneLow", 32'(bus.done), 32'd0);

      // Back-to-back: start held through DONE, second operand x=2
      bus.x     = 16'd4;
      bus.start = 1'b1;
      @(posedge clk); #1;             // E0
      bus.x     = 16'd2;
      repeat (3) @(posedge clk);
      #1;
      chk("b2b.busyE3", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;             // E4
      chk("b2b.done1", 32'(bus.done), 32'd1);
      chk("b2b.y1", 32'(bus.y), 32'd75);
      @(posedge clk); #1;             // E5 accept in DONE
      bus.start = 1'b0;
      chk("b2b.busyAccept", 32'(bus.busy), 32'd1);
      chk("b2b.doneLow", 32'(bus.done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b.doneEarly", 32'(bus.done), 32'd0);
      @(posedge clk); #1;             // E9
      chk("b2b.done2", 32'(bus.done), 32'd1);
      chk("b2b.y2", 32'(bus.y), 32'd29);
      chk("b2b.ovf2", 32'(bus.ovf), 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset after E2 of an evaluation
      bus.x     = 16'd4;
      bus.start = 1'b1;
      @(posedge clk); #1;             // E0
      bus.start = 1'b0;
      repeat (2) @(posedge clk);      // E1, E2
      #2;
      rst = 1'b1;
      #1;
      chk("arst.busy", 32'(bus.busy), 32'd0);
      chk("arst.done", 32'(bus.done), 32'd0);
      chk("arst.y", 32'(bus.y), 32'd0);
      chk("arst.ovf", 32'(bus.ovf), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("arst.noDone", 32'(bus.done), 32'd0);
      end
      runEval("postRst", 16'd1, 16'd3, 16'd5, 16'd7, 16'd15, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
